// File: rtl/biriscv_csr_arbiter_pkg.sv
// Shared types for the CSR arbiter: FSM state encoding, op owner,
// CSR exception codes and the fixed operand values used for debug ops.
package biriscv_csr_arbiter_pkg;

  // state        | meaning
  // ST_IDLE      | no op in flight, grant one requester
  // ST_ISSUE     | opcode presented to the CSR unit for one cycle
  // ST_E1        | CSR unit result sampled
  // ST_CORE_WAIT | core op wrote/trapped, wait for it to retire
  // ST_DBG_WB    | debug op write strobe to the CSR file
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_E1        = 3'd2,
    ST_CORE_WAIT = 3'd3,
    ST_DBG_WB    = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_DBG  = 1'b1
  } owner_t;

  localparam logic [5:0] EXCEPTION_NONE                = 6'h00;
  localparam logic [5:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h12;

  // Debug ops are synthesised as register-source forms reading rs1 = x1.
  localparam logic [4:0] DBG_RA_IDX = 5'd1;

  function automatic logic [11:0] csr_addr(input logic [31:0] opcode);
    return opcode[31:20];
  endfunction

endpackage

// File: rtl/biriscv_csr_arbiter_rr_arb2.sv
// Two-way round-robin grant. Bit 0 has priority out of reset; after each
// accepted grant priority moves to the requester that did not win.
module biriscv_csr_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  // Grant: contention resolved by the pointer, a lone request always wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  // Pointer: point at the loser of the accepted grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/biriscv_csr_arbiter.sv
// Serialises core and debug CSR ops onto the single CSR execute unit.
// Optional watchdog on CORE_WAIT: define BIRISCV_CSR_ARB_TIMEOUT_EN.
module biriscv_csr_arbiter
  import biriscv_csr_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_valid_i,
  output logic        core_ready_o,
  input  logic [31:0] core_opcode_i,
  input  logic [31:0] core_pc_i,
  input  logic        core_invalid_i,
  input  logic [4:0]  core_ra_idx_i,
  input  logic [31:0] core_ra_operand_i,
  input  logic        core_retire_i,
  input  logic        flush_i,
  input  logic        dbg_valid_i,
  output logic        dbg_ready_o,
  input  logic [31:0] dbg_opcode_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_rsp_valid_o,
  output logic [31:0] dbg_rsp_data_o,
  output logic        dbg_rsp_err_o,
  output logic        csr_opcode_valid_o,
  output logic [31:0] csr_opcode_o,
  output logic [31:0] csr_pc_o,
  output logic        csr_invalid_o,
  output logic [4:0]  csr_ra_idx_o,
  output logic [31:0] csr_ra_operand_o,
  input  logic        csr_result_write_i,
  input  logic [31:0] csr_result_value_i,
  input  logic [31:0] csr_result_wdata_i,
  input  logic [5:0]  csr_result_exception_i,
  output logic        dbg_wb_write_o,
  output logic [11:0] dbg_wb_waddr_o,
  output logic [31:0] dbg_wb_wdata_o,
  output logic        core_result_gate_o,
  output logic        busy_o,
  output logic        timeout_o
);

  arb_state_t  state_q, state_d;
  owner_t      owner_q;
  logic [31:0] opcode_q, pc_q, operand_q;
  logic        invalid_q;
  logic [4:0]  ra_idx_q;
  logic [31:0] rsp_data_q, wb_data_q;
  logic [11:0] wb_addr_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [1:0]  req, gnt;
  logic        idle, accept, core_flush, result_fault, wd_hit;

  assign idle         = (state_q == ST_IDLE);
  assign core_flush   = flush_i && (owner_q == OWNER_CORE);
  assign result_fault = (csr_result_exception_i != EXCEPTION_NONE);

  // Requests only count while idle and out of reset; a flush hides the core.
  assign req    = (idle && rst_ni) ? {dbg_valid_i, core_valid_i && !flush_i} : 2'b00;
  assign accept = (gnt != 2'b00);

  assign core_ready_o = gnt[0];
  assign dbg_ready_o  = gnt[1];

  biriscv_csr_arbiter_rr_arb2 u_rr (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .req     (req),
    .advance (accept),
    .gnt     (gnt)
  );

`ifdef BIRISCV_CSR_ARB_TIMEOUT_EN
  logic [7:0] wd_cnt_q;

  assign wd_hit = (state_q == ST_CORE_WAIT) && (wd_cnt_q == 8'(TIMEOUT_CYCLES));

  // Watchdog: held at zero outside CORE_WAIT, so it starts clean on entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_cnt_q <= 8'd0;
    end else if (state_q != ST_CORE_WAIT) begin
      wd_cnt_q <= 8'd0;
    end else if (!wd_hit) begin
      wd_cnt_q <= wd_cnt_q + 8'd1;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign wd_hit             = 1'b0;
`endif

  assign timeout_o = wd_hit && !core_retire_i && !flush_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state strobes.
  always_comb begin
    state_d            = state_q;
    csr_opcode_valid_o = 1'b0;
    core_result_gate_o = 1'b0;
    dbg_wb_write_o     = 1'b0;
    busy_o             = !idle;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        csr_opcode_valid_o = !core_flush;
        state_d            = core_flush ? ST_IDLE : ST_E1;
      end
      ST_E1: begin
        if (owner_q == OWNER_CORE) begin
          core_result_gate_o = !flush_i;
          if (flush_i)                                  state_d = ST_IDLE;
          else if (result_fault || csr_result_write_i)  state_d = ST_CORE_WAIT;
          else                                          state_d = ST_IDLE;
        end else begin
          state_d = (csr_result_write_i && !result_fault) ? ST_DBG_WB : ST_IDLE;
        end
      end
      ST_CORE_WAIT: begin
        if (core_retire_i || flush_i || wd_hit) state_d = ST_IDLE;
      end
      ST_DBG_WB: begin
        dbg_wb_write_o = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture on grant, result capture in E1, debug response pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q     <= OWNER_CORE;
      opcode_q    <= 32'd0;
      pc_q        <= 32'd0;
      operand_q   <= 32'd0;
      invalid_q   <= 1'b0;
      ra_idx_q    <= 5'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'd0;
      wb_addr_q   <= 12'd0;
      wb_data_q   <= 32'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      if (accept) begin
        if (gnt[0]) begin
          owner_q   <= OWNER_CORE;
          opcode_q  <= core_opcode_i;
          pc_q      <= core_pc_i;
          operand_q <= core_ra_operand_i;
          invalid_q <= core_invalid_i;
          ra_idx_q  <= core_ra_idx_i;
        end else begin
          owner_q   <= OWNER_DBG;
          opcode_q  <= dbg_opcode_i;
          pc_q      <= 32'd0;
          operand_q <= dbg_wdata_i;
          invalid_q <= 1'b0;
          ra_idx_q  <= DBG_RA_IDX;
        end
      end
      if ((state_q == ST_E1) && (owner_q == OWNER_DBG)) begin
        rsp_data_q <= csr_result_value_i;
        if (result_fault) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
        end else if (csr_result_write_i) begin
          wb_addr_q <= csr_addr(opcode_q);
          wb_data_q <= csr_result_wdata_i;
        end else begin
          rsp_valid_q <= 1'b1;
        end
      end
      if (state_q == ST_DBG_WB) begin
        rsp_valid_q <= 1'b1;
      end
    end
  end

  assign csr_opcode_o     = opcode_q;
  assign csr_pc_o         = pc_q;
  assign csr_invalid_o    = invalid_q;
  assign csr_ra_idx_o     = ra_idx_q;
  assign csr_ra_operand_o = operand_q;
  assign dbg_rsp_valid_o  = rsp_valid_q;
  assign dbg_rsp_data_o   = rsp_data_q;
  assign dbg_rsp_err_o    = rsp_err_q;
  assign dbg_wb_waddr_o   = wb_addr_q;
  assign dbg_wb_wdata_o   = wb_data_q;

endmodule

// File: tb/tb_biriscv_csr_arbiter.sv
// Directed bench for biriscv_csr_arbiter (default build, watchdog disabled).
module tb_biriscv_csr_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_valid_i, core_ready_o, core_invalid_i, core_retire_i, flush_i;
  logic [31:0] core_opcode_i, core_pc_i, core_ra_operand_i;
  logic [4:0]  core_ra_idx_i;
  logic        dbg_valid_i, dbg_ready_o, dbg_rsp_valid_o, dbg_rsp_err_o;
  logic [31:0] dbg_opcode_i, dbg_wdata_i, dbg_rsp_data_o;
  logic        csr_opcode_valid_o, csr_invalid_o;
  logic [31:0] csr_opcode_o, csr_pc_o, csr_ra_operand_o;
  logic [4:0]  csr_ra_idx_o;
  logic        csr_result_write_i;
  logic [31:0] csr_result_value_i, csr_result_wdata_i;
  logic [5:0]  csr_result_exception_i;
  logic        dbg_wb_write_o, core_result_gate_o, busy_o, timeout_o;
  logic [11:0] dbg_wb_waddr_o;
  logic [31:0] dbg_wb_wdata_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  biriscv_csr_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
    .core_opcode_i(core_opcode_i), .core_pc_i(core_pc_i),
    .core_invalid_i(core_invalid_i), .core_ra_idx_i(core_ra_idx_i),
    .core_ra_operand_i(core_ra_operand_i), .core_retire_i(core_retire_i),
    .flush_i(flush_i),
    .dbg_valid_i(dbg_valid_i), .dbg_ready_o(dbg_ready_o),
    .dbg_opcode_i(dbg_opcode_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_rsp_valid_o(dbg_rsp_valid_o), .dbg_rsp_data_o(dbg_rsp_data_o),
    .dbg_rsp_err_o(dbg_rsp_err_o),
    .csr_opcode_valid_o(csr_opcode_valid_o), .csr_opcode_o(csr_opcode_o),
    .csr_pc_o(csr_pc_o), .csr_invalid_o(csr_invalid_o),
    .csr_ra_idx_o(csr_ra_idx_o), .csr_ra_operand_o(csr_ra_operand_o),
    .csr_result_write_i(csr_result_write_i), .csr_result_value_i(csr_result_value_i),
    .csr_result_wdata_i(csr_result_wdata_i), .csr_result_exception_i(csr_result_exception_i),
    .dbg_wb_write_o(dbg_wb_write_o), .dbg_wb_waddr_o(dbg_wb_waddr_o),
    .dbg_wb_wdata_o(dbg_wb_wdata_o), .core_result_gate_o(core_result_gate_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_result();
    csr_result_write_i     = 1'b0;
    csr_result_value_i     = 32'd0;
    csr_result_wdata_i     = 32'd0;
    csr_result_exception_i = 6'd0;
  endtask

  initial begin
    rst_ni            = 1'b0;
    core_valid_i      = 1'b1;
    dbg_valid_i       = 1'b1;
    core_opcode_i     = 32'h3401_1073;
    core_pc_i         = 32'h8000_0100;
    core_invalid_i    = 1'b0;
    core_ra_idx_i     = 5'd2;
    core_ra_operand_i = 32'hDEAD_BEEF;
    core_retire_i     = 1'b0;
    flush_i           = 1'b0;
    dbg_opcode_i      = 32'h3000_A073;
    dbg_wdata_i       = 32'h0000_0008;
    clear_result();

    // Reset held with both requesters valid.
    tick(); tick(); tick();
    chk("rst_core_ready", core_ready_o, 0);
    chk("rst_dbg_ready", dbg_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_opvalid", csr_opcode_valid_o, 0);
    chk("rst_rsp_valid", dbg_rsp_valid_o, 0);
    chk("rst_wb_write", dbg_wb_write_o, 0);
    chk("rst_gate", core_result_gate_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_opcode", csr_opcode_o, 0);

    // Core wins first grant after reset; CSRRW with write=1.
    rst_ni = 1'b1;
    #1;
    chk("first_core_ready", core_ready_o, 1);
    chk("first_dbg_ready", dbg_ready_o, 0);
    tick();
    chk("core_issue_valid", csr_opcode_valid_o, 1);
    chk("core_issue_opcode", csr_opcode_o, 32'h3401_1073);
    chk("core_issue_pc", csr_pc_o, 32'h8000_0100);
    chk("core_issue_ra_idx", csr_ra_idx_o, 5'd2);
    chk("core_issue_operand", csr_ra_operand_o, 32'hDEAD_BEEF);
    chk("core_issue_busy", busy_o, 1);
    chk("core_issue_dbg_ready", dbg_ready_o, 0);
    core_valid_i = 1'b0;
    dbg_valid_i  = 1'b0;
    csr_result_write_i = 1'b1;
    csr_result_value_i = 32'h5;
    csr_result_wdata_i = 32'hDEAD_BEEF;
    tick();
    chk("core_e1_gate", core_result_gate_o, 1);
    chk("core_e1_opvalid", csr_opcode_valid_o, 0);
    tick();
    clear_result();
    chk("core_wait_busy", busy_o, 1);
    chk("core_wait_gate", core_result_gate_o, 0);
    tick();
    chk("core_wait_busy2", busy_o, 1);
    chk("core_wait_timeout", timeout_o, 0);
    core_retire_i = 1'b1;
    tick();
    core_retire_i = 1'b0;
    chk("core_retired_busy", busy_o, 0);

    // Debug CSRRS 0x300: write path, flush during E1 must not abort it.
    dbg_valid_i = 1'b1;
    #1;
    chk("dbg_ready", dbg_ready_o, 1);
    tick();
    dbg_valid_i = 1'b0;
    chk("dbg_issue_valid", csr_opcode_valid_o, 1);
    chk("dbg_issue_opcode", csr_opcode_o, 32'h3000_A073);
    chk("dbg_issue_ra_idx", csr_ra_idx_o, 5'd1);
    chk("dbg_issue_operand", csr_ra_operand_o, 32'h8);
    chk("dbg_issue_pc", csr_pc_o, 32'h0);
    csr_result_write_i = 1'b1;
    csr_result_value_i = 32'h1800;
    csr_result_wdata_i = 32'h1808;
    tick();
    chk("dbg_e1_gate", core_result_gate_o, 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    clear_result();
    chk("dbg_wb_write", dbg_wb_write_o, 1);
    chk("dbg_wb_waddr", dbg_wb_waddr_o, 12'h300);
    chk("dbg_wb_wdata", dbg_wb_wdata_o, 32'h1808);
    chk("dbg_wb_rsp_early", dbg_rsp_valid_o, 0);
    tick();
    chk("dbg_rsp_valid", dbg_rsp_valid_o, 1);
    chk("dbg_rsp_data", dbg_rsp_data_o, 32'h1800);
    chk("dbg_rsp_err", dbg_rsp_err_o, 0);
    chk("dbg_rsp_wb_off", dbg_wb_write_o, 0);
    chk("dbg_rsp_busy", busy_o, 0);
    tick();
    chk("dbg_rsp_pulse", dbg_rsp_valid_o, 0);

    // Debug op with illegal-instruction exception: error response, no write.
    dbg_valid_i = 1'b1;
    #1;
    chk("dbgx_ready", dbg_ready_o, 1);
    tick();
    dbg_valid_i = 1'b0;
    csr_result_exception_i = 6'h12;
    csr_result_write_i     = 1'b1;
    csr_result_value_i     = 32'h0000_ABCD;
    tick();
    tick();
    clear_result();
    chk("dbgx_rsp_valid", dbg_rsp_valid_o, 1);
    chk("dbgx_rsp_err", dbg_rsp_err_o, 1);
    chk("dbgx_rsp_data", dbg_rsp_data_o, 32'h0000_ABCD);
    chk("dbgx_no_wb", dbg_wb_write_o, 0);
    chk("dbgx_busy", busy_o, 0);

    // Both valid continuously: grants alternate core, dbg, core, dbg.
    core_valid_i = 1'b1;
    dbg_valid_i  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt%0d_core_ready", i), core_ready_o, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("alt%0d_dbg_ready", i), dbg_ready_o, (i % 2 == 0) ? 0 : 1);
      tick();
      chk($sformatf("alt%0d_ra_idx", i), csr_ra_idx_o, (i % 2 == 0) ? 5'd2 : 5'd1);
      chk($sformatf("alt%0d_no_ready", i), {core_ready_o, dbg_ready_o}, 2'b00);
      tick();
      chk($sformatf("alt%0d_gate", i), core_result_gate_o, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("alt%0d_busy", i), busy_o, 1);
      tick();
    end
    dbg_valid_i = 1'b0;

    // Flush in IDLE hides the core request for that cycle.
    flush_i = 1'b1;
    #1;
    chk("flush_blocks_core", core_ready_o, 0);
    flush_i = 1'b0;
    #1;
    chk("unflushed_core_ready", core_ready_o, 1);

    // Flush during CORE_WAIT: back to IDLE, pending debug granted next.
    tick();
    core_valid_i = 1'b0;
    dbg_valid_i  = 1'b1;
    csr_result_write_i = 1'b1;
    tick();
    tick();
    clear_result();
    chk("fl_wait_busy", busy_o, 1);
    chk("fl_wait_dbg_ready", dbg_ready_o, 0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_idle_busy", busy_o, 0);
    chk("fl_idle_dbg_ready", dbg_ready_o, 1);
    tick();
    dbg_valid_i = 1'b0;
    chk("fl_dbg_issue", csr_opcode_valid_o, 1);
    chk("fl_dbg_ra_idx", csr_ra_idx_o, 5'd1);
    tick();
    tick();
    chk("fl_dbg_rsp", dbg_rsp_valid_o, 1);

    // Retire and flush together in CORE_WAIT: single return to IDLE.
    core_valid_i = 1'b1;
    tick();
    core_valid_i = 1'b0;
    csr_result_write_i = 1'b1;
    tick();
    tick();
    clear_result();
    chk("rf_wait_busy", busy_o, 1);
    core_retire_i = 1'b1;
    flush_i       = 1'b1;
    tick();
    core_retire_i = 1'b0;
    flush_i       = 1'b0;
    chk("rf_idle_busy", busy_o, 0);
    tick();
    chk("rf_stays_idle", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
